// File: rtl/mem_io_responder_if.sv
// Data-port and TX-stream bundle between the core/board and mem_io_responder.
// master: the core and serial transmitter side; slave: the responder.
interface mem_io_responder_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wea;
    logic        re;
    logic        instr_retired;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output addr, wdata, wea, re, instr_retired, tx_ready,
        input  rdata, tx_data, tx_valid
    );

    modport slave (
        input  addr, wdata, wea, re, instr_retired, tx_ready,
        output rdata, tx_data, tx_valid
    );
endinterface

// File: rtl/mem_io_responder.sv
// Data-side memory responder: byte-writable RAM at 0x1xxxxxxx, and MMIO at
// 0x8xxxxxxx holding a byte TX FIFO and (optionally) cycle/instret counters.
// Reads are registered with one-cycle latency.
// Optional feature: define MEM_IO_COUNTERS_EN to build the counters.
module mem_io_responder #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned FIFO_LOG2  = 3
) (
    input logic               clk,
    input logic               reset,
    mem_io_responder_if.slave bus
);
    localparam int unsigned FifoDepth = 2 ** FIFO_LOG2;
    localparam int unsigned RamWords  = 2 ** DEPTH_LOG2;

    // MMIO word addresses (byte address >> 2)
    localparam logic [29:0] AddrStatus = 30'h2000_0000;
    localparam logic [29:0] AddrTxPush = 30'h2000_0001;
    localparam logic [29:0] AddrCycle  = 30'h2000_0004;
    localparam logic [29:0] AddrInstr  = 30'h2000_0005;
    localparam logic [29:0] AddrClear  = 30'h2000_0006;

    logic [29:0]           word_addr;
    logic                  is_ram;
    logic                  is_mmio;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic                  unused_addr;

    assign word_addr   = bus.addr[31:2];
    assign is_ram      = (bus.addr[31:28] == 4'h1);
    assign is_mmio     = (bus.addr[31:28] == 4'h8);
    assign ram_idx     = bus.addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^bus.addr[1:0];

    // ---------------- Data RAM (not reset) ----------------
    logic [31:0] ram [RamWords];

    // Byte-lane writes; reads are taken combinationally before this edge (read-first).
    always_ff @(posedge clk) begin
        if (is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wea[i]) begin
                    ram[ram_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]           fifo_q [FifoDepth];
    logic [7:0]           fifo_d [FifoDepth];
    logic [FIFO_LOG2-1:0] head_q, head_d, tail_q, tail_d;
    logic [FIFO_LOG2:0]   count_q, count_d;
    logic                 empty, full, push_req, push, pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (FIFO_LOG2 + 1)'(FifoDepth));
    assign pop      = !empty && bus.tx_ready;
    assign push_req = (word_addr == AddrTxPush) && bus.wea[0];
    // A pop in the same cycle frees a slot, so a push while full is still accepted.
    assign push     = push_req && (!full || pop);

    assign bus.tx_valid = !empty;
    assign bus.tx_data  = fifo_q[head_q];

    // FIFO next state: storage write at tail, pointer and count updates.
    always_comb begin
        fifo_d  = fifo_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            fifo_d[tail_q] = bus.wdata[7:0];
            tail_d         = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q  <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            fifo_q  <= fifo_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // ---------------- Counters ----------------
    logic [31:0] cycle_rd, instr_rd;

`ifdef MEM_IO_COUNTERS_EN
    logic [31:0] cycle_q, cycle_d, instr_q, instr_d;
    logic        cnt_clear;

    assign cnt_clear = (word_addr == AddrClear) && (bus.wea != 4'b0000);

    // Free-running counters; a clear write takes priority over the increment.
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        instr_d = instr_q + {31'd0, bus.instr_retired};
        if (cnt_clear) begin
            cycle_d = '0;
            instr_d = '0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign cycle_rd = cycle_q;
    assign instr_rd = instr_q;
`else
    logic unused_instr_retired;

    assign unused_instr_retired = bus.instr_retired;
    assign cycle_rd = '0;
    assign instr_rd = '0;
`endif

    // ---------------- Read path ----------------
    logic [31:0] rdata_q, rdata_d;

    assign bus.rdata = rdata_q;

    // Select read data from pre-edge state; hold when no read is requested.
    always_comb begin
        rdata_d = rdata_q;
        if (bus.re) begin
            rdata_d = '0;
            if (is_ram) begin
                rdata_d = ram[ram_idx];
            end else if (is_mmio) begin
                case (word_addr)
                    AddrStatus: rdata_d = {30'd0, empty, !full};
                    AddrCycle:  rdata_d = cycle_rd;
                    AddrInstr:  rdata_d = instr_rd;
                    default:    rdata_d = '0;
                endcase
            end
        end
    end

    // Registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder (RAM, TX FIFO, counters, reset).
// Counter expectations follow whether MEM_IO_COUNTERS_EN is defined.
module tb_mem_io_responder;
`ifdef MEM_IO_COUNTERS_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_bad;

    mem_io_responder_if bus ();

    mem_io_responder #(
        .DEPTH_LOG2(12),
        .FIFO_LOG2 (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        bus.addr  = a;
        bus.wdata = d;
        bus.wea   = we;
        step();
        bus.wea   = 4'b0000;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.re   = 1'b1;
        step();
        d        = bus.rdata;
        bus.re   = 1'b0;
        bus.addr = 32'h0;
    endtask

    logic [31:0] v;
    logic [7:0]  drain_exp [8];

    initial begin
        n_checks          = 0;
        n_bad             = 0;
        reset             = 1'b1;
        bus.addr          = 32'h0;
        bus.wdata         = 32'h0;
        bus.wea           = 4'b0000;
        bus.re            = 1'b0;
        bus.instr_retired = 1'b0;
        bus.tx_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check_eq("rst_rdata", bus.rdata, 32'h0);
        check_eq("rst_tx_valid", {31'd0, bus.tx_valid}, 32'h0);
        check_eq("rst_tx_data", {24'd0, bus.tx_data}, 32'h0);
        bus_read(32'h8000_0000, v);
        check_eq("rst_status", v, 32'h3);

        // RAM byte-lane writes
        bus_write(32'h1000_0008, 32'hDEAD_BEEF, 4'hF);
        bus_write(32'h1000_0008, 32'h00AA_0000, 4'b0100);
        bus_read(32'h1000_0008, v);
        check_eq("ram_byte_merge", v, 32'hDEAA_BEEF);
        step();
        check_eq("rdata_hold", bus.rdata, 32'hDEAA_BEEF);
        bus_read(32'h1000_4008, v);
        check_eq("ram_alias", v, 32'hDEAA_BEEF);

        // Read-first on same-cycle read/write
        bus_write(32'h1000_0000, 32'h1111_1111, 4'hF);
        bus.addr  = 32'h1000_0000;
        bus.wdata = 32'h2222_2222;
        bus.wea   = 4'hF;
        bus.re    = 1'b1;
        step();
        bus.wea   = 4'b0000;
        bus.re    = 1'b0;
        check_eq("ram_read_first", bus.rdata, 32'h1111_1111);
        bus_read(32'h1000_0000, v);
        check_eq("ram_new_data", v, 32'h2222_2222);

        // Unmapped region
        bus_write(32'h2000_0008, 32'h1234_5678, 4'hF);
        bus_read(32'h2000_0008, v);
        check_eq("unmapped_read", v, 32'h0);
        bus_read(32'h8000_0004, v);
        check_eq("txpush_read", v, 32'h0);

        // FIFO basic push/drain
        check_eq("fifo_empty_valid", {31'd0, bus.tx_valid}, 32'h0);
        bus_write(32'h8000_0004, 32'h0000_0041, 4'b0001);
        check_eq("fifo_valid_after_push", {31'd0, bus.tx_valid}, 32'h1);
        check_eq("fifo_head_41", {24'd0, bus.tx_data}, 32'h41);
        bus_write(32'h8000_0004, 32'h0000_0042, 4'b0001);
        bus_write(32'h8000_0004, 32'h0000_0043, 4'b0001);
        check_eq("fifo_head_stable", {24'd0, bus.tx_data}, 32'h41);
        bus.tx_ready = 1'b1;
        check_eq("fifo_out_41", {24'd0, bus.tx_data}, 32'h41);
        step();
        check_eq("fifo_out_42", {24'd0, bus.tx_data}, 32'h42);
        step();
        check_eq("fifo_out_43", {24'd0, bus.tx_data}, 32'h43);
        step();
        check_eq("fifo_drained", {31'd0, bus.tx_valid}, 32'h0);
        bus.tx_ready = 1'b0;

        // FIFO overflow: 0x08 dropped, then push+pop while full
        for (int i = 0; i < 9; i++) begin
            bus_write(32'h8000_0004, 32'(i), 4'b0001);
        end
        bus_read(32'h8000_0000, v);
        check_eq("fifo_full_status", v, 32'h0);
        bus.tx_ready = 1'b1;
        bus_write(32'h8000_0004, 32'h0000_0009, 4'b0001);
        bus.tx_ready = 1'b0;
        bus_read(32'h8000_0000, v);
        check_eq("fifo_full_after_pushpop", v, 32'h0);
        check_eq("fifo_head_advanced", {24'd0, bus.tx_data}, 32'h01);
        drain_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09};
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("fifo_drain_%0d", i), {24'd0, bus.tx_data}, {24'd0, drain_exp[i]});
            step();
        end
        check_eq("fifo_drain_empty", {31'd0, bus.tx_valid}, 32'h0);
        bus.tx_ready = 1'b0;

        // Counters
        bus_write(32'h8000_0018, 32'h0, 4'b0001);
        for (int i = 0; i < 10; i++) begin
            bus.instr_retired = (i % 2 == 0);
            step();
        end
        bus.instr_retired = 1'b0;
        bus_read(32'h8000_0010, v);
        check_eq("cycle_count", v, CntEn ? 32'd10 : 32'd0);
        bus_read(32'h8000_0014, v);
        check_eq("instr_count", v, CntEn ? 32'd5 : 32'd0);
        bus.instr_retired = 1'b1;
        bus_write(32'h8000_0018, 32'h0, 4'b1000);
        bus.instr_retired = 1'b0;
        bus_read(32'h8000_0010, v);
        check_eq("cycle_after_clear", v, 32'd0);
        bus_read(32'h8000_0014, v);
        check_eq("instr_clear_wins", v, 32'd0);
        bus_read(32'h8000_0018, v);
        check_eq("clear_read", v, 32'd0);

        // Mid-operation reset
        bus_read(32'h1000_0000, v);
        check_eq("pre_reset_rdata", v, 32'h2222_2222);
        for (int i = 0; i < 4; i++) begin
            bus_write(32'h8000_0004, 32'h0000_0050 + 32'(i), 4'b0001);
        end
        check_eq("pre_reset_valid", {31'd0, bus.tx_valid}, 32'h1);
        reset = 1'b1;
        #1;
        check_eq("async_reset_valid", {31'd0, bus.tx_valid}, 32'h0);
        check_eq("async_reset_rdata", bus.rdata, 32'h0);
        check_eq("async_reset_tx_data", {24'd0, bus.tx_data}, 32'h0);
        step();
        reset = 1'b0;
        bus_read(32'h8000_0000, v);
        check_eq("post_reset_status", v, 32'h3);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
